ffe_fir4: RTL and testbench

//  4-tap feed-forward equalizer (FIR): y[n] = H0*x[n] + H1*x[n-1] + H2*x[n-2] + H3*x[n-3].

---
 rtl/ffe_fir4_if.sv | 16 +
 rtl/ffe_fir4.sv | 115 +++++++++++
 tb/tb_ffe_fir4.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ffe_fir4_if.sv
// Sample-in / result-out bundle for the ffe_fir4 equalizer.
// master = sample source + slicer side, slave = equalizer.
interface ffe_fir4_if #(
   parameter int W = 12
);
   // load is a level: while high, DATA_IN is stable and one sample is taken per
   // LOAD_PERIOD clocks. valid_out is a one-clock pulse marking a fresh DATA_OUT;
   // there is no back-pressure, so the consumer must take every pulse.
   logic                load;
   logic signed [W-1:0] DATA_IN;
   logic signed [W-1:0] DATA_OUT;
   logic                valid_out;

   modport master (output load, DATA_IN, input DATA_OUT, valid_out);
   modport slave  (input load, DATA_IN, output DATA_OUT, valid_out);
endinterface

// File: rtl/ffe_fir4.sv
// 4-tap feed-forward equalizer, signed Q5.6 in/out, two-clock latency.
// Define FFE_SAT_EN to clamp the output instead of wrapping on overflow.
module ffe_fir4 #(
   parameter int                  W           = 12,
   parameter int                  FRAC        = 6,
   parameter int                  LOAD_PERIOD = 4,
   parameter logic signed [W-1:0] H0          = 12'sd32,
   parameter logic signed [W-1:0] H1          = -12'sd16,
   parameter logic signed [W-1:0] H2          = 12'sd10,
   parameter logic signed [W-1:0] H3          = -12'sd4
) (
   input logic       clk,
   input logic       rst,
   ffe_fir4_if.slave bus
);

   localparam int CW = (LOAD_PERIOD > 1) ? $clog2(LOAD_PERIOD) : 1;
   localparam int PW = 2 * W;
   localparam int SW = PW + 2;

   logic [CW-1:0]       cnt;
   logic                accept;
   logic signed [W-1:0] x0, x1, x2, x3;
   logic signed [PW-1:0] p0, p1, p2, p3;
   logic                s1, s2;
   logic signed [SW-1:0] sum;
   logic signed [W-1:0] res;

   // One accept per LOAD_PERIOD clocks of held load; a low load rearms at once.
   assign accept = bus.load && (cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (!bus.load) begin
         cnt <= '0;
      end else if (cnt == '0) begin
         cnt <= CW'(LOAD_PERIOD - 1);
      end else begin
         cnt <= cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x0 <= '0;
         x1 <= '0;
         x2 <= '0;
         x3 <= '0;
         s1 <= 1'b0;
      end else begin
         s1 <= accept;
         if (accept) begin
            x3 <= x2;
            x2 <= x1;
            x1 <= x0;
            x0 <= bus.DATA_IN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p0 <= '0;
         p1 <= '0;
         p2 <= '0;
         p3 <= '0;
         s2 <= 1'b0;
      end else begin
         s2 <= s1;
         p0 <= x0 * H0;
         p1 <= x1 * H1;
         p2 <= x2 * H2;
         p3 <= x3 * H3;
      end
   end

   always_comb begin
      sum = SW'(p0) + SW'(p1) + SW'(p2) + SW'(p3);
   end

`ifdef FFE_SAT_EN
   localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (W - 1)) - 1);
   localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - SW'(1);
   logic signed [SW-1:0] shifted;

   always_comb begin
      shifted = sum >>> FRAC;
      res     = shifted[W-1:0];
      if (shifted > SAT_MAX) begin
         res = SAT_MAX[W-1:0];
      end else if (shifted < SAT_MIN) begin
         res = SAT_MIN[W-1:0];
      end
   end
`else
   // Arithmetic shift floors toward -inf; the cast keeps the low bits (wrap).
   always_comb begin
      res = W'(sum >>> FRAC);
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.DATA_OUT  <= '0;
         bus.valid_out <= 1'b0;
      end else begin
         bus.valid_out <= s2;
         if (s2) begin
            bus.DATA_OUT <= res;
         end
      end
   end

endmodule

// File: tb/tb_ffe_fir4.sv
// Directed bench for ffe_fir4: default taps, accept timing, reset, overflow and floor.
// Overflow expectation follows FFE_SAT_EN.
module tb_ffe_fir4;

   logic clk_TB = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   pulses = 0;
   int   c0;
   int   sat_exp;
   logic [11:0] exp_q[$];
   int   pulse_cyc[$];

   always #5 clk_TB = ~clk_TB;
   always @(posedge clk_TB) cyc <= cyc + 1;

   ffe_fir4_if bus ();
   ffe_fir4_if s_bus ();
   ffe_fir4_if f_bus ();

   ffe_fir4 u_dut (.clk(clk_TB), .rst(rst), .bus(bus));

   ffe_fir4 #(.LOAD_PERIOD(1), .H0(12'sd64), .H1(12'sd64), .H2(12'sd0), .H3(12'sd0))
      u_sat (.clk(clk_TB), .rst(rst), .bus(s_bus));

   ffe_fir4 #(.LOAD_PERIOD(1), .H0(12'sd32), .H1(12'sd0), .H2(12'sd0), .H3(12'sd0))
      u_flr (.clk(clk_TB), .rst(rst), .bus(f_bus));

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; each task ends at that point.
   task automatic hold(input logic signed [11:0] d, input int n);
      bus.load    = 1'b1;
      bus.DATA_IN = d;
      repeat (n) @(posedge clk_TB);
      #1;
   endtask

   task automatic gap(input int n);
      bus.load = 1'b0;
      repeat (n) @(posedge clk_TB);
      #1;
   endtask

   // Scoreboard: every valid_out pulse of the main DUT must match the queue head.
   always @(negedge clk_TB) begin
      if (rst === 1'b1 && bus.valid_out === 1'b1) begin
         pulses++;
         pulse_cyc.push_back(cyc);
         check("exp_avail", (exp_q.size() > 0) ? 1 : 0, 1);
         if (exp_q.size() > 0) check("dout", $signed(bus.DATA_OUT), $signed(exp_q.pop_front()));
      end
   end

   initial begin
      rst = 1'b1;
      bus.load = 1'b0;   bus.DATA_IN = '0;
      s_bus.load = 1'b0; s_bus.DATA_IN = '0;
      f_bus.load = 1'b0; f_bus.DATA_IN = '0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk_TB);
      #1;
      check("rst_dout", $signed(bus.DATA_OUT), 0);
      check("rst_valid", bus.valid_out, 0);
      rst = 1'b1;
      gap(1);

      // Default taps, mixed held/gapped loads
      pulses = 0;
      exp_q.push_back(12'(480));
      exp_q.push_back(12'(400));
      exp_q.push_back(12'(758));
      exp_q.push_back(12'(636));
      exp_q.push_back(12'(-798));
      hold(12'sd960, 4);
      hold(12'sd1280, 4);
      gap(2);
      hold(12'sd1856, 4);
      gap(2);
      hold(12'sd1920, 4);
      hold(-12'sd1056, 4);
      gap(4);
      check("seq_pulses", pulses, 5);

      // Reset while a sample is in flight
      pulses = 0;
      hold(12'sd100, 1);
      bus.load = 1'b0;
      rst = 1'b0;
      #1;
      check("mid_rst_dout", $signed(bus.DATA_OUT), 0);
      check("mid_rst_valid", bus.valid_out, 0);
      @(posedge clk_TB); #1;
      @(posedge clk_TB); #1;
      rst = 1'b1;
      gap(4);
      check("mid_rst_pulses", pulses, 0);
      check("mid_rst_hold", $signed(bus.DATA_OUT), 0);

      // Load held 12 clocks: three accepts, results two clocks after each
      pulses = 0;
      pulse_cyc.delete();
      c0 = cyc;
      exp_q.push_back(12'(32));
      exp_q.push_back(12'(16));
      exp_q.push_back(12'(26));
      hold(12'sd64, 12);
      gap(4);
      check("held_pulses", pulses, 3);
      if (pulse_cyc.size() == 3) begin
         check("held_t0", pulse_cyc[0], c0 + 3);
         check("held_t1", pulse_cyc[1], c0 + 7);
         check("held_t2", pulse_cyc[2], c0 + 11);
      end

      // Single-clock load pulse
      pulses = 0;
      pulse_cyc.delete();
      c0 = cyc;
      exp_q.push_back(12'(54));
      hold(12'sd128, 1);
      gap(6);
      check("short_pulses", pulses, 1);
      if (pulse_cyc.size() == 1) check("short_t0", pulse_cyc[0], c0 + 3);

      // Overflow and floor on the auxiliary instances
`ifdef FFE_SAT_EN
      sat_exp = 2047;
`else
      sat_exp = -2;
`endif
      s_bus.load = 1'b1; s_bus.DATA_IN = 12'sd2047;
      f_bus.load = 1'b1; f_bus.DATA_IN = -12'sd1;
      @(posedge clk_TB); #1;
      f_bus.load = 1'b0;
      @(posedge clk_TB); #1;
      s_bus.load = 1'b0;
      @(negedge clk_TB);
      check("sat_v_early", s_bus.valid_out, 0);
      @(negedge clk_TB);
      check("sat_v1", s_bus.valid_out, 1);
      check("sat_first", $signed(s_bus.DATA_OUT), 2047);
      check("flr_v", f_bus.valid_out, 1);
      check("flr_dout", $signed(f_bus.DATA_OUT), -1);
      @(negedge clk_TB);
      check("sat_v2", s_bus.valid_out, 1);
      check("sat_second", $signed(s_bus.DATA_OUT), sat_exp);
      check("flr_v_done", f_bus.valid_out, 0);

      check("exp_q_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
